// File: rtl/lvds_video_pkg.sv
// Shared video types, default raster timing and colour constants for the LVDS pixel source.
package lvds_video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int unsigned H_ACTIVE = 1440;
  localparam int unsigned H_FP     = 24;
  localparam int unsigned H_SYNC   = 32;
  localparam int unsigned H_BP     = 64;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 900;
  localparam int unsigned V_FP     = 3;
  localparam int unsigned V_SYNC   = 6;
  localparam int unsigned V_BP     = 17;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b0;

  localparam int unsigned CNT_W = 12;

  localparam rgb888_t RED   = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb888_t GREEN = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb888_t BLUE  = '{r: 8'h00, g: 8'h00, b: 8'hFF};
  localparam rgb888_t WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb888_t BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/lvds_bar_pattern.sv
// Combinational four-bar colour decoder: horizontal position -> red/green/blue/white bar.
module lvds_bar_pattern #(
  parameter int unsigned H_ACTIVE = lvds_video_pkg::H_ACTIVE,
  parameter int unsigned CNT_W    = lvds_video_pkg::CNT_W
) (
  input  logic [CNT_W-1:0]        h,
  output lvds_video_pkg::rgb888_t rgb
);
  import lvds_video_pkg::*;

  localparam int unsigned BAR_W = H_ACTIVE / 4;

  always_comb begin
    rgb = WHITE;
    if (h < CNT_W'(BAR_W))
      rgb = RED;
    else if (h < CNT_W'(2 * BAR_W))
      rgb = GREEN;
    else if (h < CNT_W'(3 * BAR_W))
      rgb = BLUE;
  end

endmodule

// File: rtl/lvds_timing_gen.sv
// Full-frame raster timing and pixel source feeding the LVDS serializer, one pixel per pix_en.
// Define LVDS_TEST_PATTERN_EN to replace the ext_* inputs with an internal colour-bar pattern.
module lvds_timing_gen #(
  parameter int unsigned H_ACTIVE = lvds_video_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = lvds_video_pkg::H_FP,
  parameter int unsigned H_SYNC   = lvds_video_pkg::H_SYNC,
  parameter int unsigned H_BP     = lvds_video_pkg::H_BP,
  parameter int unsigned V_ACTIVE = lvds_video_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = lvds_video_pkg::V_FP,
  parameter int unsigned V_SYNC   = lvds_video_pkg::V_SYNC,
  parameter int unsigned V_BP     = lvds_video_pkg::V_BP,
  parameter bit          HS_POL   = lvds_video_pkg::HS_POL,
  parameter bit          VS_POL   = lvds_video_pkg::VS_POL,
  parameter int unsigned CNT_W    = lvds_video_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic [7:0]       ext_red,
  input  logic [7:0]       ext_green,
  input  logic [7:0]       ext_blue,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
  output logic [7:0]       red,
  output logic [7:0]       green,
  output logic [7:0]       blue
);
  import lvds_video_pkg::*;

  localparam int unsigned H_LAST   = H_ACTIVE + H_FP + H_SYNC + H_BP - 1;
  localparam int unsigned V_LAST   = V_ACTIVE + V_FP + V_SYNC + V_BP - 1;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             active;
  logic             hs_active;
  logic             vs_active;
  rgb888_t          src;

  always_comb begin
    active    = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));
    hs_active = (h >= CNT_W'(HS_START)) && (h < CNT_W'(HS_END));
    vs_active = (v >= CNT_W'(VS_START)) && (v < CNT_W'(VS_END));
  end

`ifdef LVDS_TEST_PATTERN_EN
  logic unused_ext;
  assign unused_ext = ^{ext_red, ext_green, ext_blue};

  lvds_bar_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .CNT_W    (CNT_W)
  ) u_bar_pattern (
    .h   (h),
    .rgb (src)
  );
`else
  assign src = '{r: ext_red, g: ext_green, b: ext_blue};
`endif

  // Outputs register the decode of the pre-increment (h,v), so the presented
  // pixel always matches hcount/vcount one clk after its strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      h           <= '0;
      v           <= '0;
      hcount      <= '0;
      vcount      <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        hcount      <= h;
        vcount      <= v;
        de          <= active;
        hsync       <= hs_active ? HS_POL : ~HS_POL;
        vsync       <= vs_active ? VS_POL : ~VS_POL;
        frame_start <= (h == '0) && (v == '0);
        red         <= active ? src.r : BLACK.r;
        green       <= active ? src.g : BLACK.g;
        blue        <= active ? src.b : BLACK.b;
        if (h == CNT_W'(H_LAST)) begin
          h <= '0;
          v <= (v == CNT_W'(V_LAST)) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lvds_timing_gen.sv
// Scoreboard bench: a default-timing instance for line-level checks and a small-raster instance for whole frames.
module tb_lvds_timing_gen;
  import lvds_video_pkg::*;

  typedef struct packed {
    logic [11:0] hc;
    logic [11:0] vc;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
  } obs_t;

  localparam logic [23:0] EXT0 = 24'h0C2238;
`ifdef LVDS_TEST_PATTERN_EN
  localparam logic [23:0] C_RED   = 24'hFF0000;
  localparam logic [23:0] C_GREEN = 24'h00FF00;
  localparam logic [23:0] C_WHITE = 24'hFFFFFF;
`else
  localparam logic [23:0] C_RED   = EXT0;
  localparam logic [23:0] C_GREEN = EXT0;
  localparam logic [23:0] C_WHITE = EXT0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       pix_a = 1'b0;
  logic       pix_b = 1'b0;
  logic [7:0] er = 8'h0C, eg = 8'h22, eb = 8'h38;

  logic [11:0] hc_a, vc_a, hc_b, vc_b;
  logic        de_a, hs_a, vs_a, fs_a, de_b, hs_b, vs_b, fs_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  lvds_timing_gen u_dut_a (
    .clk(clk), .reset(reset), .pix_en(pix_a),
    .ext_red(er), .ext_green(eg), .ext_blue(eb),
    .hcount(hc_a), .vcount(vc_a), .de(de_a), .hsync(hs_a), .vsync(vs_a),
    .frame_start(fs_a), .red(r_a), .green(g_a), .blue(b_a)
  );

  // Small raster: 16 pixels x 8 lines, positive hsync.
  lvds_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(12)
  ) u_dut_b (
    .clk(clk), .reset(reset), .pix_en(pix_b),
    .ext_red(er), .ext_green(eg), .ext_blue(eb),
    .hcount(hc_b), .vcount(vc_b), .de(de_b), .hsync(hs_b), .vsync(vs_b),
    .frame_start(fs_b), .red(r_b), .green(g_b), .blue(b_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fs_seen_b = 0;

  obs_t q_a[$];
  obs_t q_b[$];

  function automatic obs_t hv(int h, int v, logic d, logic hs, logic vs, logic fs, logic [23:0] rgb);
    obs_t o;
    o.hc = 12'(h); o.vc = 12'(v); o.de = d; o.hs = hs; o.vs = vs; o.fs = fs; o.rgb = rgb;
    return o;
  endfunction

  function automatic obs_t model(int h, int v, int ha, int hf, int hsw, int va, int vf, int vsw,
                                 bit hp, bit vp, logic [23:0] ext);
    logic act;
    logic [23:0] c;
    act = (h < ha) && (v < va);
`ifdef LVDS_TEST_PATTERN_EN
    if (h < ha / 4) c = 24'hFF0000;
    else if (h < 2 * (ha / 4)) c = 24'h00FF00;
    else if (h < 3 * (ha / 4)) c = 24'h0000FF;
    else c = 24'hFFFFFF;
`else
    c = ext;
`endif
    return hv(h, v, act,
              (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp,
              (v >= va + vf && v < va + vf + vsw) ? vp : !vp,
              (h == 0) && (v == 0),
              act ? c : 24'h0);
  endfunction

  task automatic check(string nm, obs_t a, obs_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got h=%0d v=%0d de=%b hs=%b vs=%b fs=%b rgb=%06h, expected h=%0d v=%0d de=%b hs=%b vs=%b fs=%b rgb=%06h",
               nm, $time, a.hc, a.vc, a.de, a.hs, a.vs, a.fs, a.rgb,
               e.hc, e.vc, e.de, e.hs, e.vs, e.fs, e.rgb);
    end
  endtask

  // Monitor: sample strobes on the active edge, compare on the falling edge.
  bit   rst_s, fired_a, fired_b;
  obs_t last_a = '{hc: 0, vc: 0, de: 0, hs: 1, vs: 1, fs: 0, rgb: 0};
  obs_t last_b = '{hc: 0, vc: 0, de: 0, hs: 0, vs: 1, fs: 0, rgb: 0};

  always @(posedge clk) begin
    rst_s   = reset;
    fired_a = pix_a && !reset;
    fired_b = pix_b && !reset;
  end

  always @(negedge clk) begin
    obs_t act, exp;
    act = '{hc: hc_a, vc: vc_a, de: de_a, hs: hs_a, vs: vs_a, fs: fs_a, rgb: {r_a, g_a, b_a}};
    if (rst_s) exp = '{hc: 0, vc: 0, de: 0, hs: 1, vs: 1, fs: 0, rgb: 0};
    else if (fired_a) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_sb_empty @%0t: got pixel with no expectation, required queued entry", $time);
        exp = last_a;
      end else exp = q_a.pop_front();
    end else begin
      exp = last_a; exp.fs = 1'b0;
    end
    check("a_px", act, exp);
    last_a = exp;

    act = '{hc: hc_b, vc: vc_b, de: de_b, hs: hs_b, vs: vs_b, fs: fs_b, rgb: {r_b, g_b, b_b}};
    if (fs_b) fs_seen_b++;
    if (rst_s) exp = '{hc: 0, vc: 0, de: 0, hs: 0, vs: 1, fs: 0, rgb: 0};
    else if (fired_b) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_sb_empty @%0t: got pixel with no expectation, required queued entry", $time);
        exp = last_b;
      end else exp = q_b.pop_front();
    end else begin
      exp = last_b; exp.fs = 1'b0;
    end
    check("b_px", act, exp);
    last_b = exp;
  end

  int ah = 0, av = 0, bh = 0, bv = 0;

  task automatic pulse_a(obs_t e, int gap);
    q_a.push_back(e);
    pix_a = 1'b1;
    @(negedge clk);
    pix_a = 1'b0;
    repeat (gap) @(negedge clk);
    if (ah == 1559) begin ah = 0; av = (av == 925) ? 0 : av + 1; end
    else ah++;
  endtask

  task automatic step_a(int gap);
    pulse_a(model(ah, av, 1440, 24, 32, 900, 3, 6, 1'b0, 1'b0, {er, eg, eb}), gap);
  endtask

  task automatic step_b(int gap);
    q_b.push_back(model(bh, bv, 8, 2, 3, 4, 1, 2, 1'b1, 1'b0, {er, eg, eb}));
    pix_b = 1'b1;
    @(negedge clk);
    pix_b = 1'b0;
    repeat (gap) @(negedge clk);
    if (bh == 15) begin bh = 0; bv = (bv == 7) ? 0 : bv + 1; end
    else bh++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // First pixel, bar boundaries, hsync window, line wrap.
    for (int i = 0; i < 2 * 1560 + 2; i++) begin
      case (i)
        0:    pulse_a(hv(0, 0, 1, 1, 1, 1, C_RED), 0);
        359:  pulse_a(hv(359, 0, 1, 1, 1, 0, C_RED), 0);
        360:  pulse_a(hv(360, 0, 1, 1, 1, 0, C_GREEN), 0);
        1080: pulse_a(hv(1080, 0, 1, 1, 1, 0, C_WHITE), 0);
        1439: pulse_a(hv(1439, 0, 1, 1, 1, 0, C_WHITE), 0);
        1440: pulse_a(hv(1440, 0, 0, 1, 1, 0, 24'h0), 0);
        1463: pulse_a(hv(1463, 0, 0, 1, 1, 0, 24'h0), 0);
        1464: pulse_a(hv(1464, 0, 0, 0, 1, 0, 24'h0), 0);
        1495: pulse_a(hv(1495, 0, 0, 0, 1, 0, 24'h0), 0);
        1496: pulse_a(hv(1496, 0, 0, 1, 1, 0, 24'h0), 0);
        1559: pulse_a(hv(1559, 0, 0, 1, 1, 0, 24'h0), 0);
        1560: pulse_a(hv(0, 1, 1, 1, 1, 0, C_RED), 0);
        default: step_a(0);
      endcase
    end

    // Small raster: two full frames plus a few pixels, back-to-back strobes.
    for (int i = 0; i < 2 * 128 + 3; i++) step_b(0);

    // Run A to (700,10), then reset with pix_en high.
    while (!(ah == 700 && av == 10)) step_a(0);
    pix_a = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    pix_a = 1'b0;
    reset = 1'b0;
    ah = 0; av = 0; bh = 0; bv = 0;
    repeat (2) @(negedge clk);
    pulse_a(hv(0, 0, 1, 1, 1, 1, C_RED), 0);
    pulse_a(hv(1, 0, 1, 1, 1, 0, C_RED), 0);

    // Strobe every 7 clks with changing external colour.
    for (int i = 0; i < 130; i++) begin
      {er, eg, eb} = 24'($urandom);
      step_b(6);
    end
    for (int i = 0; i < 12; i++) begin
      {er, eg, eb} = 24'($urandom);
      step_a(6);
    end

    repeat (3) @(negedge clk);
    n_tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d/%0d pending, required 0/0", q_a.size(), q_b.size());
    end
    n_tests++;
    if (fs_seen_b != 5) begin
      n_fail++;
      $display("FAIL b_frame_count: got %0d frame_start pulses, required 5", fs_seen_b);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
